// File: rtl/redundant_to_int_pkg.sv
// ============================================================================
// Module  : redundant_to_int_pkg
// Purpose : Shared types and constants for the redundant-to-integer converter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package redundant_to_int_pkg;

   localparam int R2I_N_LIMB  = 4;
   localparam int R2I_LIMB_W  = 76;
   localparam int R2I_RADIX_W = 72;
   localparam int R2I_OUT_W   = R2I_N_LIMB*R2I_RADIX_W + R2I_LIMB_W - R2I_RADIX_W + 1;

   typedef logic [R2I_LIMB_W-1:0]             fp_div4_t;
   typedef fp_div4_t [R2I_N_LIMB-1:0]         redundant_poly_L1;
   typedef logic [R2I_OUT_W-1:0]              r2i_out_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SUB  = 2'd2,
      DONE = 2'd3
   } r2i_state_t;

   // Curve modulus M_tilde, used only by the optional conditional subtract.
   localparam r2i_out_t M_TILDE = (r2i_out_t'(1) << 286) + r2i_out_t'(64'h9B5E_21C7_0F13_A4D1);

endpackage

`default_nettype wire

// File: rtl/redundant_to_int_limb_carry_add.sv
// ============================================================================
// Module  : limb_carry_add
// Purpose : One carry-resolution step: limb + carry -> radix digit, carry out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module limb_carry_add #(
   parameter int LIMB_W  = 76,
   parameter int RADIX_W = 72
) (
   input  logic [LIMB_W-1:0]         limb,
   input  logic [LIMB_W-RADIX_W:0]   carry_in,
   output logic [RADIX_W-1:0]        digit,
   output logic [LIMB_W-RADIX_W:0]   carry_out,
   output logic [LIMB_W:0]           sum
);

   assign sum       = {1'b0, limb} + (LIMB_W+1)'(carry_in);
   assign digit     = sum[RADIX_W-1:0];
   assign carry_out = sum[LIMB_W:RADIX_W];

endmodule

`default_nettype wire

// File: rtl/redundant_to_int.sv
// ============================================================================
// Module  : redundant_to_int
// Purpose : Limb-serial carry resolution of a redundant value into binary.
//           Define R2I_COND_SUB_EN to add a one-cycle conditional MOD subtract.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module redundant_to_int
   import redundant_to_int_pkg::*;
#(
   parameter int N_LIMB  = R2I_N_LIMB,
   parameter int LIMB_W  = R2I_LIMB_W,
   parameter int RADIX_W = R2I_RADIX_W
`ifdef R2I_COND_SUB_EN
   ,
   parameter logic [R2I_OUT_W-1:0] MOD = M_TILDE
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_LIMB*LIMB_W-1:0]     din,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_LIMB*RADIX_W+LIMB_W-RADIX_W:0] dout
);

   localparam int OUT_W   = N_LIMB*RADIX_W + LIMB_W - RADIX_W + 1;
   localparam int CARRY_W = LIMB_W - RADIX_W + 1;
   localparam int IDX_W   = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
   localparam int TOP_LSB = (N_LIMB-1)*RADIX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIMB-1);

   r2i_state_t                       state_q, state_d;
   logic [N_LIMB-1:0][LIMB_W-1:0]    limb_q, limb_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [CARRY_W-1:0]               carry_q, carry_d;
   logic [OUT_W-1:0]                 acc_q, acc_d;

   logic [RADIX_W-1:0]               step_digit;
   logic [CARRY_W-1:0]               step_carry;
   logic [LIMB_W:0]                  step_sum;

   limb_carry_add #(
      .LIMB_W  (LIMB_W),
      .RADIX_W (RADIX_W)
   ) u_limb_carry_add (
      .limb      (limb_q[idx_q]),
      .carry_in  (carry_q),
      .digit     (step_digit),
      .carry_out (step_carry),
      .sum       (step_sum)
   );

   always_comb begin
      state_d = state_q;
      limb_d  = limb_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               limb_d  = din;
               idx_d   = '0;
               carry_d = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = step_carry;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Top field keeps the whole sum so the final carry is never lost.
               acc_d[TOP_LSB +: LIMB_W+1] = step_sum;
`ifdef R2I_COND_SUB_EN
               state_d = SUB;
`else
               state_d = DONE;
`endif
            end else begin
               acc_d[int'(idx_q)*RADIX_W +: RADIX_W] = step_digit;
            end
         end
         SUB: begin
`ifdef R2I_COND_SUB_EN
            if (acc_q >= OUT_W'(MOD)) begin
               acc_d = acc_q - OUT_W'(MOD);
            end
`endif
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         limb_q  <= '0;
         idx_q   <= '0;
         carry_q <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         limb_q  <= limb_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign dout      = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_redundant_to_int.sv
// ============================================================================
// Module  : tb_redundant_to_int
// Purpose : Self-checking bench for redundant_to_int (table, random, corners).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_redundant_to_int;
   import redundant_to_int_pkg::*;

`ifdef R2I_COND_SUB_EN
   localparam int EXP_LAT = R2I_N_LIMB + 1;
`else
   localparam int EXP_LAT = R2I_N_LIMB;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   redundant_poly_L1 din;
   logic             out_valid;
   logic             out_ready;
   r2i_out_t         dout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   redundant_to_int dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout)
   );

   typedef struct {
      redundant_poly_L1 din;
      r2i_out_t         exp;
   } vec_t;

   function automatic r2i_out_t cond_sub(input r2i_out_t r);
`ifdef R2I_COND_SUB_EN
      if (r >= M_TILDE) return r - M_TILDE;
`endif
      return r;
   endfunction

   // The integer value of a redundant number is just the weighted sum of its limbs.
   function automatic r2i_out_t ref_model(input redundant_poly_L1 d);
      r2i_out_t r = '0;
      for (int i = 0; i < R2I_N_LIMB; i++) begin
         r += r2i_out_t'(d[i]) << (i*R2I_RADIX_W);
      end
      return cond_sub(r);
   endfunction

   function automatic fp_div4_t rand_limb();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return fp_div4_t'({$urandom(), $urandom(), $urandom()});
         default: return fp_div4_t'({$urandom(), $urandom(), $urandom()}) >> (R2I_LIMB_W-R2I_RADIX_W);
      endcase
   endfunction

   function automatic redundant_poly_L1 rand_din();
      redundant_poly_L1 d;
      for (int i = 0; i < R2I_N_LIMB; i++) d[i] = rand_limb();
      return d;
   endfunction

   task automatic check(input string nm, input r2i_out_t act, input r2i_out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic start(input redundant_poly_L1 d);
      int waited = 0;
      while (!in_ready && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) check("in_ready_timeout", r2i_out_t'(in_ready), r2i_out_t'(1));
      din      = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic handshake(input string nm);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({nm, "_ovalid_drop"}, r2i_out_t'(out_valid), r2i_out_t'(0));
   endtask

   task automatic convert(input string nm, input redundant_poly_L1 d, input r2i_out_t exp,
                          input bit chk_lat);
      int cyc;
      start(d);
      wait_done(cyc);
      if (chk_lat) check({nm, "_latency"}, r2i_out_t'(cyc), r2i_out_t'(EXP_LAT));
      check({nm, "_dout"}, dout, exp);
      handshake(nm);
   endtask

   vec_t             tbl[6];
   redundant_poly_L1 da, db;
   r2i_out_t         ones76, wsum, exp_a;
   int               cyc;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;

      ones76 = (r2i_out_t'(1) << R2I_LIMB_W) - r2i_out_t'(1);
      wsum   = r2i_out_t'(1) + (r2i_out_t'(1) << 72) + (r2i_out_t'(1) << 144) + (r2i_out_t'(1) << 216);

      tbl[0].din = '0;
      tbl[0].exp = '0;
      tbl[1].din = '0;
      tbl[1].din[0] = fp_div4_t'(1) << R2I_RADIX_W;
      tbl[1].exp = r2i_out_t'(1) << 72;
      tbl[2].din = '1;
      tbl[2].exp = ones76 * wsum;
      tbl[3].din[0] = 76'h0_0123_4567_89AB_CDEF_F;
      tbl[3].din[1] = 76'h0_FEDC_BA98_7654_3210_1;
      tbl[3].din[2] = 76'h0_A5A5_5A5A_C3C3_3C3C_7;
      tbl[3].din[3] = 76'h0_1111_2222_3333_4444_5;
      tbl[3].exp = {1'b0, tbl[3].din[3], tbl[3].din[2][71:0], tbl[3].din[1][71:0], tbl[3].din[0][71:0]};
      // A full low limb ripples a carry through two all-ones digits.
      tbl[4].din[0] = '1;
      tbl[4].din[1] = (fp_div4_t'(1) << 72) - fp_div4_t'(1);
      tbl[4].din[2] = (fp_div4_t'(1) << 72) - fp_div4_t'(1);
      tbl[4].din[3] = '0;
      tbl[4].exp = (r2i_out_t'(1) << 216) + (r2i_out_t'(15) << 72) - r2i_out_t'(1);
      tbl[5].din = '0;
      tbl[5].din[3] = '1;
      tbl[5].exp = ones76 << 216;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", r2i_out_t'(out_valid), r2i_out_t'(0));
      check("rst_in_ready", r2i_out_t'(in_ready), r2i_out_t'(0));
      check("rst_dout", dout, '0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", r2i_out_t'(in_ready), r2i_out_t'(1));

      for (int i = 0; i < 6; i++) begin
         convert($sformatf("table%0d", i), tbl[i].din, cond_sub(tbl[i].exp), 1'b1);
      end

      for (int i = 0; i < 200; i++) begin
         da = rand_din();
         convert($sformatf("rand%0d", i), da, ref_model(da), (i % 10) == 0);
      end

      // Backpressure with an in_valid pulse during RUN that must be ignored.
      da = rand_din();
      db = rand_din();
      exp_a = ref_model(da);
      start(da);
      din      = db;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(cyc);
      check("bp_dout", dout, exp_a);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", r2i_out_t'(out_valid), r2i_out_t'(1));
         check("bp_in_ready", r2i_out_t'(in_ready), r2i_out_t'(0));
         check("bp_dout_hold", dout, exp_a);
      end
      handshake("bp");
      check("bp_in_ready_after", r2i_out_t'(in_ready), r2i_out_t'(1));

      // Output handshake coincident with in_valid: capture happens one cycle later.
      da = rand_din();
      db = rand_din();
      start(da);
      wait_done(cyc);
      check("simul_first_dout", dout, ref_model(da));
      din       = db;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("simul_ovalid_drop", r2i_out_t'(out_valid), r2i_out_t'(0));
      check("simul_idle_ready", r2i_out_t'(in_ready), r2i_out_t'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(cyc);
      check("simul_latency", r2i_out_t'(cyc), r2i_out_t'(EXP_LAT));
      check("simul_second_dout", dout, ref_model(db));
      handshake("simul");

      // Reset while idx=2 with maximal carries, then a carry-sensitive conversion.
      da = '1;
      start(da);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", r2i_out_t'(out_valid), r2i_out_t'(0));
      check("midrst_dout", dout, '0);
      check("midrst_in_ready_in_rst", r2i_out_t'(in_ready), r2i_out_t'(0));
      rst = 1'b0;
      #1;
      check("midrst_in_ready", r2i_out_t'(in_ready), r2i_out_t'(1));
      db = '0;
      db[1] = fp_div4_t'(5);
      convert("after_rst", db, cond_sub(r2i_out_t'(5) << 72), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
